// File: rtl/cdc_cmd_line_assembler_if.sv
// Console handshake bundle between the CDC endpoint, the line assembler and the command processor.
// "master" is the assembler side, "slave" is the endpoint/consumer side.
interface cdc_cmd_line_assembler_if;
    logic       dtr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] echo_data;
    logic       echo_valid;
    logic       echo_ready;
    logic [7:0] line_data;
    logic       line_valid;
    logic       line_last;
    logic       line_ready;
    logic [7:0] line_len;
    logic       line_err;
    logic       line_cancel;

    modport master (
        input  dtr, rx_data, rx_valid, echo_ready, line_ready,
        output rx_ready, echo_data, echo_valid, line_data, line_valid,
               line_last, line_len, line_err, line_cancel
    );

    modport slave (
        output dtr, rx_data, rx_valid, echo_ready, line_ready,
        input  rx_ready, echo_data, echo_valid, line_data, line_valid,
               line_last, line_len, line_err, line_cancel
    );
endinterface

// File: rtl/cdc_cmd_line_assembler.sv
// Line editor for the CDC debug console: collects keystrokes, echoes them with
// backspace/cancel/overflow handling and streams finished lines to the command processor.
module cdc_cmd_line_assembler #(
    parameter int LINE_MAX = 64,
    parameter int ECHO_EN  = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    cdc_cmd_line_assembler_if.master        bus
);

    localparam int         AW      = $clog2(LINE_MAX);
    localparam logic [7:0] LMAX    = 8'(LINE_MAX);
    localparam logic       ECHO_ON = (ECHO_EN != 0);

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        ECHO    = 3'd1,
        ERASE   = 3'd2,
        NEWLINE = 3'd3,
        EMIT    = 3'd4,
        DISCARD = 3'd5
    } state_t;

    state_t     state_r, state_s;
    logic [7:0] len_r, len_s;
    logic       last_cr_r, last_cr_s;
    logic [1:0] step_r, step_s;
    logic [7:0] emit_idx_r, emit_idx_s;
    logic [7:0] emit_nxt_s;
    logic [7:0] line_buf_r [0:LINE_MAX-1];

    logic       wr_en_s;
    logic       nl_start_s;
    logic       rx_fire_s;
    logic       echo_done_s;
    logic       line_fire_s;
    logic       printable_s;
    logic       erase_key_s;

    logic       rx_ready_r, rx_ready_s;
    logic [7:0] echo_data_r, echo_data_s;
    logic       echo_valid_r, echo_valid_s;
    logic [7:0] line_data_r, line_data_s;
    logic       line_valid_r, line_valid_s;
    logic       line_last_r, line_last_s;
    logic [7:0] line_len_r, line_len_s;
    logic       line_err_r, line_err_s;
    logic       line_cancel_r, line_cancel_s;

    // With echo disabled the echo bus stays quiet at zero.
    function automatic logic [7:0] echo_byte(input logic [7:0] b);
        return ECHO_ON ? b : 8'h00;
    endfunction

    assign rx_fire_s   = bus.rx_valid & rx_ready_r;
    assign echo_done_s = !ECHO_ON || (echo_valid_r && bus.echo_ready);
    assign line_fire_s = line_valid_r & bus.line_ready;
    assign printable_s = (bus.rx_data >= 8'h20) && (bus.rx_data <= 8'h7E);
    assign erase_key_s = (bus.rx_data == 8'h08) || (bus.rx_data == 8'h7F);
    assign emit_nxt_s  = emit_idx_r + 8'd1;

    // Next-state and next-output logic for the line editor.
    always_comb begin
        state_s       = state_r;
        len_s         = len_r;
        last_cr_s     = last_cr_r;
        step_s        = step_r;
        emit_idx_s    = emit_idx_r;
        echo_valid_s  = echo_valid_r;
        echo_data_s   = echo_data_r;
        line_valid_s  = line_valid_r;
        line_data_s   = line_data_r;
        line_last_s   = line_last_r;
        line_len_s    = line_len_r;
        line_err_s    = 1'b0;
        line_cancel_s = 1'b0;
        wr_en_s       = 1'b0;
        nl_start_s    = 1'b0;

        if (!bus.dtr) begin
            // Host gone: abandon everything and drop whatever arrives meanwhile.
            state_s      = COLLECT;
            len_s        = 8'd0;
            last_cr_s    = 1'b0;
            step_s       = 2'd0;
            echo_valid_s = 1'b0;
            line_valid_s = 1'b0;
            line_last_s  = 1'b0;
        end else begin
            case (state_r)
                COLLECT: begin
                    if (rx_fire_s) begin
                        last_cr_s = (bus.rx_data == 8'h0D);
                        if (printable_s) begin
                            if (len_r < LMAX) begin
                                wr_en_s      = 1'b1;
                                len_s        = len_r + 8'd1;
                                state_s      = ECHO;
                                echo_valid_s = ECHO_ON;
                                echo_data_s  = echo_byte(bus.rx_data);
                            end else begin
                                state_s = DISCARD;
                            end
                        end else if (erase_key_s) begin
                            if (len_r != 8'd0) begin
                                len_s        = len_r - 8'd1;
                                state_s      = ERASE;
                                step_s       = 2'd0;
                                echo_valid_s = ECHO_ON;
                                echo_data_s  = echo_byte(8'h08);
                            end else begin
                                len_s = len_r;
                            end
                        end else if (bus.rx_data == 8'h0D) begin
                            nl_start_s = 1'b1;
                        end else if (bus.rx_data == 8'h0A) begin
                            nl_start_s = !last_cr_r;
                        end else if (bus.rx_data == 8'h03) begin
                            len_s         = 8'd0;
                            line_cancel_s = 1'b1;
                            nl_start_s    = 1'b1;
                        end else begin
                            nl_start_s = 1'b0;
                        end
                    end else begin
                        last_cr_s = last_cr_r;
                    end
                end
                ECHO: begin
                    if (echo_done_s) begin
                        state_s      = COLLECT;
                        echo_valid_s = 1'b0;
                    end else begin
                        state_s = ECHO;
                    end
                end
                ERASE: begin
                    // Rub-out on the terminal: back, blank, back.
                    if (echo_done_s) begin
                        if (!ECHO_ON || step_r == 2'd2) begin
                            state_s      = COLLECT;
                            echo_valid_s = 1'b0;
                        end else begin
                            step_s      = step_r + 2'd1;
                            echo_data_s = (step_r == 2'd0) ? 8'h20 : 8'h08;
                        end
                    end else begin
                        state_s = ERASE;
                    end
                end
                NEWLINE: begin
                    if (echo_done_s) begin
                        if (!ECHO_ON || step_r == 2'd1) begin
                            echo_valid_s = 1'b0;
                            if (len_r != 8'd0) begin
                                state_s      = EMIT;
                                emit_idx_s   = 8'd0;
                                line_valid_s = 1'b1;
                                line_data_s  = line_buf_r[0];
                                line_last_s  = (len_r == 8'd1);
                                line_len_s   = len_r;
                            end else begin
                                state_s = COLLECT;
                                len_s   = 8'd0;
                            end
                        end else begin
                            step_s      = 2'd1;
                            echo_data_s = 8'h0A;
                        end
                    end else begin
                        state_s = NEWLINE;
                    end
                end
                EMIT: begin
                    if (line_fire_s) begin
                        if (line_last_r) begin
                            state_s      = COLLECT;
                            len_s        = 8'd0;
                            line_valid_s = 1'b0;
                            line_last_s  = 1'b0;
                        end else begin
                            emit_idx_s  = emit_nxt_s;
                            line_data_s = line_buf_r[emit_nxt_s[AW-1:0]];
                            line_last_s = ((emit_nxt_s + 8'd1) == len_r);
                        end
                    end else begin
                        state_s = EMIT;
                    end
                end
                DISCARD: begin
                    if (rx_fire_s) begin
                        last_cr_s = (bus.rx_data == 8'h0D);
                        if ((bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A)) begin
                            line_err_s = 1'b1;
                            len_s      = 8'd0;
                            nl_start_s = 1'b1;
                        end else begin
                            nl_start_s = 1'b0;
                        end
                    end else begin
                        last_cr_s = last_cr_r;
                    end
                end
                default: begin
                    state_s = COLLECT;
                    len_s   = 8'd0;
                end
            endcase

            if (nl_start_s) begin
                state_s      = NEWLINE;
                step_s       = 2'd0;
                echo_valid_s = ECHO_ON;
                echo_data_s  = echo_byte(8'h0D);
            end else begin
                wr_en_s = wr_en_s & 1'b1;
            end
        end

        rx_ready_s = (state_s == COLLECT) || (state_s == DISCARD);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= COLLECT;
            len_r         <= 8'd0;
            last_cr_r     <= 1'b0;
            step_r        <= 2'd0;
            emit_idx_r    <= 8'd0;
            rx_ready_r    <= 1'b0;
            echo_data_r   <= 8'd0;
            echo_valid_r  <= 1'b0;
            line_data_r   <= 8'd0;
            line_valid_r  <= 1'b0;
            line_last_r   <= 1'b0;
            line_len_r    <= 8'd0;
            line_err_r    <= 1'b0;
            line_cancel_r <= 1'b0;
        end else begin
            state_r       <= state_s;
            len_r         <= len_s;
            last_cr_r     <= last_cr_s;
            step_r        <= step_s;
            emit_idx_r    <= emit_idx_s;
            rx_ready_r    <= rx_ready_s;
            echo_data_r   <= echo_data_s;
            echo_valid_r  <= echo_valid_s;
            line_data_r   <= line_data_s;
            line_valid_r  <= line_valid_s;
            line_last_r   <= line_last_s;
            line_len_r    <= line_len_s;
            line_err_r    <= line_err_s;
            line_cancel_r <= line_cancel_s;
        end
    end

    // Character storage; contents are only meaningful below len_r, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            line_buf_r[len_r[AW-1:0]] <= bus.rx_data;
        end
    end

    assign bus.rx_ready    = rx_ready_r;
    assign bus.echo_data   = echo_data_r;
    assign bus.echo_valid  = echo_valid_r;
    assign bus.line_data   = line_data_r;
    assign bus.line_valid  = line_valid_r;
    assign bus.line_last   = line_last_r;
    assign bus.line_len    = line_len_r;
    assign bus.line_err    = line_err_r;
    assign bus.line_cancel = line_cancel_r;

endmodule

// File: tb/tb_cdc_cmd_line_assembler.sv
// Bench for cdc_cmd_line_assembler: table of keystroke strings with expected echo/line streams,
// checked through scoreboard queues, plus hand-written stall and dtr-drop sequences.
module tb_cdc_cmd_line_assembler;

    logic       clk = 1'b0;
    logic       rst, dtr, rx_valid, echo_ready, line_ready;
    logic [7:0] rx_data;
    bit         sel;

    always #5 clk = ~clk;

    cdc_cmd_line_assembler_if bus0 ();
    cdc_cmd_line_assembler_if bus1 ();

    assign bus0.dtr = dtr;         assign bus1.dtr = dtr;
    assign bus0.rx_data = rx_data; assign bus1.rx_data = rx_data;
    assign bus0.rx_valid = rx_valid; assign bus1.rx_valid = rx_valid;
    assign bus0.echo_ready = echo_ready; assign bus1.echo_ready = echo_ready;
    assign bus0.line_ready = line_ready; assign bus1.line_ready = line_ready;

    cdc_cmd_line_assembler #(.LINE_MAX(64), .ECHO_EN(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    cdc_cmd_line_assembler #(.LINE_MAX(4),  .ECHO_EN(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    wire       m_rx_ready    = sel ? bus1.rx_ready    : bus0.rx_ready;
    wire [7:0] m_echo_data   = sel ? bus1.echo_data   : bus0.echo_data;
    wire       m_echo_valid  = sel ? bus1.echo_valid  : bus0.echo_valid;
    wire [7:0] m_line_data   = sel ? bus1.line_data   : bus0.line_data;
    wire       m_line_valid  = sel ? bus1.line_valid  : bus0.line_valid;
    wire       m_line_last   = sel ? bus1.line_last   : bus0.line_last;
    wire [7:0] m_line_len    = sel ? bus1.line_len    : bus0.line_len;
    wire       m_line_err    = sel ? bus1.line_err    : bus0.line_err;
    wire       m_line_cancel = sel ? bus1.line_cancel : bus0.line_cancel;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic [7:0] len;
    } line_item_t;

    typedef struct {
        bit           sel;
        logic [127:0] rx;
        logic [127:0] echo;
        logic [127:0] line;
        int           err;
        int           cancel;
    } vec_t;

    logic [7:0] exp_echo_q [$];
    line_item_t exp_line_q [$];
    int         vectors = 0;
    int         miscompares = 0;
    int         err_cnt = 0;
    int         cancel_cnt = 0;
    logic [7:0] mon_e;
    line_item_t mon_l;
    vec_t       vecs [8];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endfunction

    function automatic int slen(input logic [127:0] s);
        int n = 0;
        for (int i = 0; i < 16; i++) if (s[8*i +: 8] != 8'h00) n = i + 1;
        return n;
    endfunction

    function automatic logic [7:0] ch(input logic [127:0] s, input int k, input int n);
        return s[8*(n-1-k) +: 8];
    endfunction

    // Monitor: every handshake pops one expected item.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_echo_valid && echo_ready) begin
                if (exp_echo_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL echo_unexpected: got %02h required none", m_echo_data);
                end else begin
                    mon_e = exp_echo_q.pop_front();
                    check("echo_data", {24'd0, m_echo_data}, {24'd0, mon_e});
                end
            end
            if (m_line_valid && line_ready) begin
                if (exp_line_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL line_unexpected: got %02h required none", m_line_data);
                end else begin
                    mon_l = exp_line_q.pop_front();
                    check("line_data", {24'd0, m_line_data}, {24'd0, mon_l.d});
                    check("line_last", {31'd0, m_line_last}, {31'd0, mon_l.last});
                    check("line_len",  {24'd0, m_line_len},  {24'd0, mon_l.len});
                end
            end
            if (m_line_err) err_cnt++;
            if (m_line_cancel) cancel_cnt++;
        end
    end

    task automatic do_reset(input bit s);
        sel = s; rst = 1'b1; dtr = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        echo_ready = 1'b1; line_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready",    {31'd0, m_rx_ready},    32'd0);
        check("rst_echo_valid",  {31'd0, m_echo_valid},  32'd0);
        check("rst_echo_data",   {24'd0, m_echo_data},   32'd0);
        check("rst_line_valid",  {31'd0, m_line_valid},  32'd0);
        check("rst_line_last",   {31'd0, m_line_last},   32'd0);
        check("rst_line_data",   {24'd0, m_line_data},   32'd0);
        check("rst_line_len",    {24'd0, m_line_len},    32'd0);
        check("rst_line_err",    {31'd0, m_line_err},    32'd0);
        check("rst_line_cancel", {31'd0, m_line_cancel}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rx_ready_after_rst", {31'd0, m_rx_ready}, 32'd1);
        err_cnt = 0; cancel_cnt = 0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        rx_data = b; rx_valid = 1'b1;
        for (int t = 0; t < 500 && !got; t++) begin
            @(negedge clk);
            got = m_rx_ready;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL rx_accept: byte %02h got no handshake, required accept within 500 cycles", b);
        end
    endtask

    task automatic send_str(input logic [127:0] s);
        int n = slen(s);
        for (int k = 0; k < n; k++) send_byte(ch(s, k, n));
    endtask

    task automatic push_exp(input logic [127:0] echo, input logic [127:0] line);
        int ne = slen(echo);
        int nl = slen(line);
        line_item_t it;
        for (int k = 0; k < ne; k++) exp_echo_q.push_back(ch(echo, k, ne));
        for (int k = 0; k < nl; k++) begin
            it.d = ch(line, k, nl); it.last = (k == nl - 1); it.len = 8'(nl);
            exp_line_q.push_back(it);
        end
    endtask

    task automatic drain_check(input int exp_err, input int exp_cancel);
        for (int t = 0; t < 1000 && (exp_echo_q.size() != 0 || exp_line_q.size() != 0); t++) begin
            @(posedge clk);
            #1;
        end
        repeat (10) @(posedge clk);
        #1;
        check("echo_left",   exp_echo_q.size(), 32'd0);
        check("line_left",   exp_line_q.size(), 32'd0);
        check("err_pulses",  err_cnt,    exp_err);
        check("cancel_pulses", cancel_cnt, exp_cancel);
        exp_echo_q.delete();
        exp_line_q.delete();
    endtask

    task automatic wait_line_byte(input logic [7:0] b, input string name);
        bit hit = 1'b0;
        for (int t = 0; t < 500 && !hit; t++) begin
            @(negedge clk);
            hit = m_line_valid && (m_line_data == b);
        end
        if (!hit) begin
            vectors++; miscompares++;
            $display("FAIL %s: line byte %02h never presented, required within 500 cycles", name, b);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, "ab\r",        "ab\r\n",              "ab",   0, 0};
        vecs[1] = '{1'b0, "abc\010d\r",  "abc\010 \010d\r\n",   "abd",  0, 0};
        vecs[2] = '{1'b0, "\010\r\nx\n", "\r\nx\r\n",           "x",    0, 0};
        vecs[3] = '{1'b1, "abcdef\rz\r", "abcd\r\nz\r\n",       "z",    1, 0};
        vecs[4] = '{1'b0, "ab\003q\r",   "ab\r\nq\r\n",         "q",    0, 1};
        vecs[5] = '{1'b0, "a\177\r",     "a\010 \010\r\n",      128'h0, 0, 0};
        vecs[6] = '{1'b1, "abcd\r",      "abcd\r\n",            "abcd", 0, 0};
        vecs[7] = '{1'b0, "a\001b\r",    "ab\r\n",              "ab",   0, 0};

        for (int i = 0; i < 8; i++) begin
            do_reset(vecs[i].sel);
            push_exp(vecs[i].echo, vecs[i].line);
            send_str(vecs[i].rx);
            drain_check(vecs[i].err, vecs[i].cancel);
        end

        // Echo back-pressure: rx must stay closed and the echo byte held.
        do_reset(1'b0);
        push_exp("ab\r\n", "ab");
        echo_ready = 1'b0;
        send_byte(8'h61);
        for (int t = 0; t < 10; t++) begin
            check("echo_stall_rx_ready",  {31'd0, m_rx_ready},   32'd0);
            check("echo_stall_valid",     {31'd0, m_echo_valid}, 32'd1);
            check("echo_stall_data",      {24'd0, m_echo_data},  32'h61);
            @(posedge clk);
            #1;
        end
        echo_ready = 1'b1;
        send_str("b\r");
        drain_check(0, 0);

        // Line back-pressure with more keystrokes waiting.
        do_reset(1'b0);
        push_exp("hello\r\nZ", "hello");
        line_ready = 1'b0;
        send_str("hello\r");
        rx_data = 8'h5A; rx_valid = 1'b1;
        wait_line_byte(8'h68, "line_stall_start");
        @(posedge clk);
        #1;
        for (int t = 0; t < 20; t++) begin
            check("line_stall_rx_ready", {31'd0, m_rx_ready},   32'd0);
            check("line_stall_valid",    {31'd0, m_line_valid}, 32'd1);
            check("line_stall_data",     {24'd0, m_line_data},  32'h68);
            @(posedge clk);
            #1;
        end
        line_ready = 1'b1;
        send_byte(8'h5A);
        drain_check(0, 0);

        // Host disconnect in the middle of a line.
        do_reset(1'b0);
        push_exp("hello\r\n", 128'h0);
        exp_line_q.push_back('{8'h68, 1'b0, 8'd5});
        exp_line_q.push_back('{8'h65, 1'b0, 8'd5});
        send_str("hello\r");
        wait_line_byte(8'h65, "dtr_second_byte");
        dtr = 1'b0;
        @(posedge clk);
        #1;
        check("dtr_line_valid", {31'd0, m_line_valid}, 32'd0);
        check("dtr_echo_valid", {31'd0, m_echo_valid}, 32'd0);
        check("dtr_rx_ready",   {31'd0, m_rx_ready},   32'd1);
        dtr = 1'b1;
        @(posedge clk);
        #1;
        push_exp("q\r\n", "q");
        send_str("q\r");
        drain_check(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cdc_cmd_line_assembler.md
# cdc_cmd_line_assembler

Line-editing front end for the CDC debug console. It consumes the console RX byte stream from the CDC endpoint (`debug_rx_*`), echoes keystrokes back on the endpoint's TX path (`debug_tx_*`), and handles backspace, cancel and overflow. It hands complete command lines to the command processor as a framed byte stream.

## Interface
Parameters:
- LINE_MAX, 64: maximum stored characters per line (2..255).
- ECHO_EN, 1: 1 = echo enabled; 0 = echo_valid never asserted and all echo steps are skipped.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- dtr  in  1  host-connected flag from the CDC endpoint.
- rx_data  in  8  console byte from the endpoint RX FIFO.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  byte accepted when rx_valid & rx_ready.
- echo_data  out  8  echo byte toward the endpoint TX FIFO.
- echo_valid  out  1  echo_data valid; held until echo_ready.
- echo_ready  in  1  TX FIFO can accept.
- line_data  out  8  command line byte.
- line_valid  out  1  line_data valid.
- line_last  out  1  final byte of the line.
- line_ready  in  1  consumer accepts on line_valid & line_ready.
- line_len  out  8  length of the line being emitted; stable while in EMIT.
- line_err  out  1  one-cycle pulse when an overflowed line is discarded.
- line_cancel  out  1  one-cycle pulse on Ctrl-C.

## Operation
- Storage: LINE_MAX x 8 buffer and a length counter `len` (0..LINE_MAX), plus a `last_cr` flag.
- States: COLLECT, ECHO, ERASE, NEWLINE, EMIT, DISCARD.
- rx_ready is 1 only in COLLECT or DISCARD, or whenever dtr=0.
- COLLECT handles each accepted byte as follows:
  - Printable 0x20–0x7E with len<LINE_MAX: store at buf[len], len+1, go to ECHO with that byte.
  - Printable with len==LINE_MAX: go to DISCARD. No echo, no store.
  - 0x08 or 0x7F with len>0: len−1, go to ERASE (echo 08,20,08). With len==0: ignored.
  - 0x0D: set last_cr, go to NEWLINE.
  - 0x0A: if last_cr=1, ignored; otherwise go to NEWLINE.
  - 0x03: len←0, pulse line_cancel, go to NEWLINE.
  - Any other control byte: ignored.
  - last_cr clears on every accepted byte other than 0x0D.
- ECHO / ERASE / NEWLINE: emit a 1/3/2-byte sequence. NEWLINE emits 0D,0A.
- After NEWLINE:
  - len>0 and not overflowed: go to EMIT.
  - Otherwise: len←0, go to COLLECT.
- DISCARD: drop bytes until 0x0D or 0x0A, then pulse line_err, len←0, go to NEWLINE (no EMIT).
- EMIT: stream buf[0..len−1] with line_last on index len−1. After the last handshake, len←0 and go to COLLECT.
- dtr=0 (any state, any cycle):
  - Next cycle: state←COLLECT, len←0, last_cr←0, echo_valid←0, line_valid←0.
  - Bytes accepted while dtr=0 are dropped.

## Timing
- Reset values: rx_ready=0, echo_valid=0, echo_data=0, line_valid=0, line_last=0, line_data=0, line_len=0, line_err=0, line_cancel=0.
- State after reset is COLLECT; rx_ready=1 from the first cycle after rst deasserts.
- All outputs are registered.
- Echo byte appears with echo_valid the cycle after the RX handshake.
- Within a multi-byte echo, the next byte is presented the cycle after each echo handshake.
- After the final echo handshake, rx_ready returns to 1 (or line_valid rises) on the next cycle.
- EMIT byte 0 is valid the cycle after the NEWLINE 0A handshake. At most one byte per cycle with line_ready held at 1.
- Holding echo_ready=0 or line_ready=0 stalls indefinitely. rx_ready stays 0 and no byte is lost or reordered.
- line_err and line_cancel assert for exactly one cycle, in the cycle the NEWLINE state is entered.
- ECHO_EN=0: ECHO/ERASE/NEWLINE each take one cycle with no echo output.

## Test plan
1. Send "ab\r" with echo_ready=line_ready=1.
   - Echo: 61,62,0D,0A.
   - Line: 61,62 with line_last on 62; line_len=2.
2. Send "abc",08,"d\r".
   - Echo: 61,62,63,08,20,08,64,0D,0A.
   - Line: 61,62,64; line_len=3.
3. Send 08 on an empty line, then "\r\n", then "x\n".
   - 08 produces no echo.
   - Echo: 0D,0A (no line), then 78,0D,0A.
   - Line: 78 with line_last; the LF after CR is ignored.
4. LINE_MAX=4, send "abcdef\r".
   - Echo: 61,62,63,64,0D,0A.
   - line_err pulses once; no line_valid.
   - Next "z\r" emits 7A.
5. Send "ab",03.
   - Echo: 61,62,0D,0A.
   - line_cancel pulses; no line.
   - Next "q\r" emits only 71.
6. Send "hello\r" with line_ready=0 for 20 cycles, and rx_valid held high with extra bytes queued.
   - rx_ready=0 throughout; the line emits intact once line_ready=1.
   - Repeat, dropping dtr at the 2nd emitted byte: line_valid=0 next cycle, len=0, rx_ready=1.
